// File: rtl/pipe_tree_cla_adder.sv
// rtl/pipe_tree_cla_adder.sv - pipelined segmented tree carry-lookahead adder/subtractor
//
// Purpose:
//   Adds (or subtracts) two WIDTH-bit operands, resolving one SEG_W-bit segment per
//   pipeline stage. Each segment is a Kogge-Stone style parallel-prefix adder built from
//   A cells (black: merge generate and propagate) and B cells (gray: merge generate only).
//   The carry between segments is registered, so the critical path is one segment tree.
//   Upper operand segments ride along in skew registers. Lower result segments ride along
//   in deskew registers, so the result leaves fully aligned after NSEG = WIDTH/SEG_W cycles.
//   A single global stall (adv) freezes the whole pipe under output backpressure.
//
// Configuration macro:
//   CLA_SAT_EN - when defined, the final stage clamps the signed result on overflow
//                (0x7FF..F on positive overflow, 0x800..0 on negative overflow).
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   in_valid  in   1      operand beat valid
//   in_ready  out  1      beat accepted this cycle when in_valid is also high
//   a, b      in   WIDTH  operands
//   cin       in   1      carry-in (ignored when sub=1)
//   sub       in   1      1: a - b computed as a + ~b + 1
//   out_valid out  1      result beat valid
//   out_ready in   1      downstream accepts the result
//   sum       out  WIDTH  result
//   cout      out  1      carry out of the MSB (inverted borrow when sub=1)
//   ovf       out  1      signed overflow

module pipe_tree_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_W;

    // A cell: full generate/propagate merge of a high group with the adjacent low group.
    function automatic logic [1:0] gp_cell_a(input logic g_hi, input logic p_hi,
                                             input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    // B cell: generate-only merge, used once the low group already reaches bit 0
    // (its generate is then the final carry and the group propagate is never needed).
    function automatic logic gp_cell_b(input logic g_hi, input logic p_hi,
                                       input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

    // One segment tree: returns {carry_out, sum[SEG_W-1:0]}.
    // The carry-in is folded into bit 0's generate so every prefix G[i] is the
    // carry out of bit i directly.
    function automatic logic [SEG_W:0] seg_cla(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic             c0);
        logic [SEG_W-1:0] p;
        logic [SEG_W-1:0] gg;
        logic [SEG_W-1:0] pp;
        logic [SEG_W-1:0] g_nxt;
        logic [SEG_W-1:0] p_nxt;
        logic [SEG_W-1:0] cvec;
        logic [1:0]       gp;
        p     = x ^ y;
        gg    = x & y;
        gg[0] = gg[0] | (p[0] & c0);
        pp    = p;
        for (int d = 1; d < SEG_W; d = d * 2) begin
            g_nxt = gg;
            p_nxt = pp;
            for (int i = d; i < SEG_W; i++) begin
                if (i < 2 * d) begin
                    g_nxt[i] = gp_cell_b(gg[i], pp[i], gg[i-d]);
                end else begin
                    gp       = gp_cell_a(gg[i], pp[i], gg[i-d], pp[i-d]);
                    g_nxt[i] = gp[1];
                    p_nxt[i] = gp[0];
                end
            end
            gg = g_nxt;
            pp = p_nxt;
        end
        cvec[0] = c0;
        for (int i = 1; i < SEG_W; i++) begin
            cvec[i] = gg[i-1];
        end
        return {gg[SEG_W-1], p ^ cvec};
    endfunction

    // Stage k registers: valid, carry out of segment k, skewed operands (b already
    // conditioned for subtraction) and the deskewed result with segments 0..k filled.
    logic [NSEG-1:0]  vld_q, vld_d;
    logic [NSEG-1:0]  cy_q, cy_d;
    logic [WIDTH-1:0] opa_q [NSEG];
    logic [WIDTH-1:0] opa_d [NSEG];
    logic [WIDTH-1:0] opb_q [NSEG];
    logic [WIDTH-1:0] opb_d [NSEG];
    logic [WIDTH-1:0] res_q [NSEG];
    logic [WIDTH-1:0] res_d [NSEG];
    logic             ovf_q, ovf_d;
    logic             adv;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign adv       = !vld_q[NSEG-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NSEG-1];
    assign sum       = res_q[NSEG-1];
    assign cout      = cy_q[NSEG-1];
    assign ovf       = ovf_q;

    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] r_src;
        logic             c_src;
        logic             v_src;
        logic [SEG_W:0]   seg;
        int               km1;

        a_src = '0;
        b_src = '0;
        r_src = '0;
        c_src = 1'b0;
        v_src = 1'b0;
        seg   = '0;
        km1   = 0;
        vld_d = vld_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        for (int k = 0; k < NSEG; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            res_d[k] = res_q[k];
        end

        if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                km1 = (k == 0) ? 0 : k - 1;
                if (k == 0) begin
                    a_src = a;
                    b_src = sub ? ~b : b;
                    c_src = sub | cin;
                    r_src = '0;
                    v_src = in_valid;
                end else begin
                    a_src = opa_q[km1];
                    b_src = opb_q[km1];
                    c_src = cy_q[km1];
                    r_src = res_q[km1];
                    v_src = vld_q[km1];
                end

                seg = seg_cla(a_src[k*SEG_W +: SEG_W], b_src[k*SEG_W +: SEG_W], c_src);
                r_src[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
                cy_d[k]  = seg[SEG_W];
                vld_d[k] = v_src;

                if (k == NSEG - 1) begin
                    // Last stage: operands are no longer needed downstream.
                    opa_d[k] = '0;
                    opb_d[k] = '0;
                    ovf_d    = (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                               (r_src[WIDTH-1] != a_src[WIDTH-1]);
`ifdef CLA_SAT_EN
                    // Overflow direction follows the operand sign: both positive
                    // clamps to max positive, both negative to min negative.
                    if (ovf_d) begin
                        r_src = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end else begin
                    opa_d[k] = a_src;
                    opb_d[k] = b_src;
                end
                res_d[k] = r_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

endmodule
